// File: rtl/image_pkg.sv
// Shared frame geometry and writer state encoding. The VGA read side imports
// this package too, so both ends of the image RAM agree on the frame layout.
package image_pkg;

  localparam int IMG_W      = 100;
  localparam int IMG_H      = 100;
  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 8;
  localparam int IMG_PIXELS = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_writer_if.sv
// Pixel stream in, RAM write port out. The writer connects through the slave
// modport; the source/display/RAM side connects through the master modport.
interface image_writer_if #(
  parameter int ADDR_W = image_pkg::ADDR_W,
  parameter int DATA_W = image_pkg::DATA_W
);

  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              wr_allow;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  pix_valid, pix_data, wr_allow,
    output pix_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output pix_valid, pix_data, wr_allow,
    input  pix_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/raster_counter.sv
// Raster-order column/row/linear-address counter with a last-pixel flag.
// The linear address steps by one per pixel, so no multiplier is needed.
module raster_counter
  import image_pkg::*;
#(
  parameter int W      = IMG_W,
  parameter int H      = IMG_H,
  parameter int ADDR_W = image_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int CW = cnt_w(W);
  localparam int RW = cnt_w(H);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  assign last = (col == CW'(W - 1)) && (row == RW'(H - 1));

  // NOTE: state registers use non-blocking assignments so every register in
  // this clock edge sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (inc) begin
      if (last) begin
        // Wrap to the origin so the counters never pass the final pixel.
        col  <= '0;
        row  <= '0;
        addr <= '0;
      end else if (col == CW'(W - 1)) begin
        col  <= '0;
        row  <= row + 1'b1;
        addr <= addr + 1'b1;
      end else begin
        col  <= col + 1'b1;
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/image_writer.sv
// Writes a raster-ordered pixel stream into the frame RAM, only while the
// display grants access, with a one-cycle registered write port.
module image_writer
  import image_pkg::*;
#(
  parameter int IMG_W  = image_pkg::IMG_W,
  parameter int IMG_H  = image_pkg::IMG_H,
  parameter int ADDR_W = image_pkg::ADDR_W,
  parameter int DATA_W = image_pkg::DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  image_writer_if.slave  bus,
  output logic           busy,
  output logic           frame_done,
  output logic           err_abort
);

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              last;
  logic [ADDR_W-1:0] addr;

  assign accept = bus.pix_valid && bus.pix_ready;

  // Any start rewinds to address 0; in WRITE it also flags the abort.
  raster_counter #(
    .W      (IMG_W),
    .H      (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .inc  (accept),
    .addr (addr),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = WRITE;
      WRITE:   if (!start && accept && last) state_next = DONE;
      DONE:    state_next = start ? WRITE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.pix_ready = (state == WRITE) && bus.wr_allow && !start;
    busy          = (state != IDLE);
    frame_done    = (state == DONE);
  end

  // A write registered in the same cycle as rst is intentionally dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      err_abort     <= 1'b0;
    end else begin
      bus.mem_we <= accept;
      if (accept) begin
        bus.mem_addr  <= addr;
        bus.mem_wdata <= bus.pix_data;
      end
      if (start && (state == WRITE)) err_abort <= 1'b1;
    end
  end

endmodule
